if_fetch_ctrl: RTL
==================

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC loaded on reset.
REQ-002 Parameter MEM_SIZE, default 256, instruction memory size in bytes; legal fetch iff pc <= MEM_SIZE-4.
REQ-003 Parameter HALT_ON_ZERO, default 1, when 1 a fetched 32'h0 word halts fetch.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  synchronous active-low reset.
REQ-006 Port imem_adr  output  64  byte address to instruction memory, combinational from pc.
REQ-007 Port imem_instr  input  32  little-endian word returned combinationally by memory for imem_adr.
REQ-008 Port branch_taken  input  1  redirect request from later stage.
REQ-009 Port branch_target  input  64  redirect byte address.
REQ-010 Port out_valid  output  1  IF/ID register holds a valid instruction.
REQ-011 Port out_ready  input  1  decode accepts this cycle; transfer = out_valid & out_ready.
REQ-012 Port out_instr  output  32  registered instruction.
REQ-013 Port out_pc  output  64  registered address of out_instr.
REQ-014 Port halted  output  1  high in HALT or FAULT state.
REQ-015 Port fault  output  1  high in FAULT state only.
REQ-016 Port fetch_count  output  32  number of transfers since reset, saturating at 32'hFFFF_FFFF.

Function
REQ-017 States: FETCH, HALT, FAULT; HALT and FAULT are exited only by reset.
REQ-018 imem_adr SHALL equal pc in every state.
REQ-019 "advance" = FETCH & !branch_taken & (!out_valid | out_ready).
REQ-020 FETCH, branch_taken with branch_target[1:0]==0: pc<=branch_target, out_valid<=0; branch has priority over stall and advance.
REQ-021 FETCH, branch_taken with branch_target[1:0]!=0: state<=FAULT, out_valid<=0, pc unchanged.
REQ-022 advance with pc > MEM_SIZE-4: state<=HALT, out_valid<=0, pc unchanged.
REQ-023 advance with HALT_ON_ZERO==1 and imem_instr==32'h0: state<=HALT, out_valid<=0, pc unchanged.
REQ-024 advance otherwise: out_valid<=1, out_instr<=imem_instr, out_pc<=pc, pc<=pc+4 (64-bit wrap).
REQ-025 FETCH, !branch_taken, out_valid & !out_ready (stall): pc, out_valid, out_instr, out_pc held.
REQ-026 Fetch latency: instruction at pc appears on out_* one edge after the advance cycle; throughput one per cycle with out_ready held high.
REQ-027 Entering HALT/FAULT drops out_valid on the same edge, even if the previous word was not yet accepted (pending word discarded); no error raised.
REQ-028 HALT/FAULT: branch_taken ignored, out_valid held 0, out_instr/out_pc held.
REQ-029 fetch_count increments on every transfer edge, including a transfer coincident with branch or halt.

Reset
REQ-030 rst_n low at a rising edge: state<=FETCH, pc<=RESET_PC, out_valid<=0, out_instr<=0, out_pc<=0, fetch_count<=0; halted=0, fault=0.
REQ-031 Reset mid-operation overrides branch, stall and transfer in the same cycle; fetch_count not incremented.
REQ-032 First out_valid=1 at the first edge after rst_n rises (one advance cycle).

Structure
REQ-033 Shared package holds state enum (FETCH/HALT/FAULT), INSTR_W=32, ADDR_W=64, PC_STEP=4.
REQ-034 No sub-module; instruction memory stays outside the block, connected via imem_adr/imem_instr.

Verification
REQ-035 Memory: 0x8B1F03E5 @0, 0xF84000A4 @4, 0 @8; out_ready=1 -> out (pc0,8B1F03E5), (pc4,F84000A4), then halted=1 with pc=8, fetch_count=2.
REQ-036 Same image, out_ready=0 for 3 cycles after first valid -> out_pc=0/out_instr=8B1F03E5 held 3 cycles, then pc4 word next cycle.
REQ-037 branch_taken=1, target=64'h30 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, imem_adr=64'h30; fetch_count unchanged.
REQ-038 branch_target=64'h32 -> fault=1, halted=1, out_valid=0; later branch_taken ignored until reset.
REQ-039 HALT_ON_ZERO=0, RESET_PC=252 -> word @252 delivered, then halted=1 with pc=256.
REQ-040 rst_n low during stall with out_valid=1 -> next edge out_valid=0, pc=RESET_PC, fetch_count=0.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package if_fetch_ctrl_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HALT  = 2'd1,
    S_FAULT = 2'd2
  } fetch_state_e;

  function automatic logic addr_aligned(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00);
  endfunction
endpackage

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch stage: drives the PC to an external memory and holds the
// fetched word in an IF/ID register with a valid/ready handshake to decode.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter int          MEM_SIZE     = 256,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] imem_adr,
  input  logic [31:0] imem_instr,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_SIZE - PC_STEP);

  fetch_state_e        r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_valid;
  logic [INSTR_W-1:0]  r_instr;
  logic [ADDR_W-1:0]   r_out_pc;
  logic [31:0]         r_count;

  logic w_xfer;
  logic w_advance;
  logic w_stop;

  assign w_xfer    = r_valid & out_ready;
  assign w_advance = (r_state == S_FETCH) & ~branch_taken & (~r_valid | out_ready);
  // Running off the end of memory or hitting a zero word ends the program.
  assign w_stop    = (r_pc > LAST_PC) | (HALT_ON_ZERO & (imem_instr == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_valid  <= 1'b0;
      r_instr  <= '0;
      r_out_pc <= '0;
      r_count  <= '0;
    end else begin
      if (w_xfer && (r_count != 32'hFFFF_FFFF))
        r_count <= r_count + 32'd1;

      if (r_state == S_FETCH) begin
        if (branch_taken) begin
          // Any pending word is on the wrong path and is dropped.
          r_valid <= 1'b0;
          if (addr_aligned(branch_target))
            r_pc <= branch_target;
          else
            r_state <= S_FAULT;
        end else if (w_advance) begin
          if (w_stop) begin
            r_state <= S_HALT;
            r_valid <= 1'b0;
          end else begin
            r_valid  <= 1'b1;
            r_instr  <= imem_instr;
            r_out_pc <= r_pc;
            r_pc     <= r_pc + ADDR_W'(PC_STEP);
          end
        end
      end
    end
  end

  assign imem_adr    = r_pc;
  assign out_valid   = r_valid;
  assign out_instr   = r_instr;
  assign out_pc      = r_out_pc;
  assign halted      = (r_state != S_FETCH);
  assign fault       = (r_state == S_FAULT);
  assign fetch_count = r_count;
endmodule
